// File: rtl/vpu_fp_minmax_lanes_pkg.sv
// Shared types and helpers for the packed-lane FP min/max unit.
// Optional flags output is enabled with VPU_FP_MINMAX_FLAGS_EN.
package vpu_fp_minmax_lanes_pkg;

    typedef enum logic {
        MINMAX_MAX = 1'b0,
        MINMAX_MIN = 1'b1
    } minmax_op_t;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam int ELEM_MAX = 32;

    // elem is right-aligned; elem_w locates the exponent field
    function automatic logic is_nan(
        input logic [ELEM_MAX-1:0] elem,
        input int exp_w,
        input int elem_w
    );
        logic exp_ones;
        logic mant_nz;
        exp_ones = 1'b1;
        mant_nz = 1'b0;
        for (int i = 0; i < ELEM_MAX; i++) begin
            if (i < elem_w - 1 - exp_w) begin
                mant_nz = mant_nz | elem[i];
            end else if (i < elem_w - 1) begin
                exp_ones = exp_ones & elem[i];
            end
        end
        return exp_ones & mant_nz;
    endfunction

endpackage

// File: rtl/vpu_fp_minmax_lanes_if.sv
// Source/destination handshake bundle for vpu_fp_minmax_lanes.
// invalid_o exists only with VPU_FP_MINMAX_FLAGS_EN.
interface vpu_fp_minmax_lanes_if #(
    parameter int NUM_LANES  = 4,
    parameter int ELEM_WIDTH = 32
);
    import vpu_fp_minmax_lanes_pkg::*;

    logic [NUM_LANES*ELEM_WIDTH-1:0] operand_0;
    logic [NUM_LANES*ELEM_WIDTH-1:0] operand_1;
    minmax_op_t                      op_i;
    logic                            start_i;
    logic                            ready_o;
    logic [NUM_LANES*ELEM_WIDTH-1:0] result_o;
    logic                            done_o;
    logic                            result_ready_i;

`ifdef VPU_FP_MINMAX_FLAGS_EN
    logic [NUM_LANES-1:0]            invalid_o;

    modport master (
        output operand_0, operand_1, op_i, start_i, result_ready_i,
        input  ready_o, result_o, done_o, invalid_o
    );
    modport slave (
        input  operand_0, operand_1, op_i, start_i, result_ready_i,
        output ready_o, result_o, done_o, invalid_o
    );
`else
    modport master (
        output operand_0, operand_1, op_i, start_i, result_ready_i,
        input  ready_o, result_o, done_o
    );
    modport slave (
        input  operand_0, operand_1, op_i, start_i, result_ready_i,
        output ready_o, result_o, done_o
    );
`endif

endinterface

// File: rtl/sal_fifo.sv
// Small synchronous FIFO with registered storage; head is zero when empty.
// Simultaneous push and pop on a full queue keeps the count.
module sal_fifo #(
    parameter int DEPTH_LG2  = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  valid_o,
    output logic [DEPTH_LG2:0]    count_o
);

    localparam int DEPTH = 1 << DEPTH_LG2;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH_LG2-1:0]  wr_ptr_q;
    logic [DEPTH_LG2-1:0]  wr_ptr_d;
    logic [DEPTH_LG2-1:0]  rd_ptr_q;
    logic [DEPTH_LG2-1:0]  rd_ptr_d;
    logic [DEPTH_LG2:0]    count_q;
    logic [DEPTH_LG2:0]    count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d = wr_ptr_q + DEPTH_LG2'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LG2'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (DEPTH_LG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LG2+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign valid_o    = count_q != '0;
    assign pop_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/vpu_fp_minmax_lane.sv
// One lane of IEEE-754 maxNum/minNum select, purely combinational.
// snan_o exists only with VPU_FP_MINMAX_FLAGS_EN.
module vpu_fp_minmax_lane
    import vpu_fp_minmax_lanes_pkg::*;
#(
    parameter int ELEM_WIDTH = 32,
    parameter int EXP_WIDTH  = 8
) (
    input  logic [ELEM_WIDTH-1:0] a_i,
    input  logic [ELEM_WIDTH-1:0] b_i,
    input  minmax_op_t            op_i,
`ifdef VPU_FP_MINMAX_FLAGS_EN
    output logic                  snan_o,
`endif
    output logic [ELEM_WIDTH-1:0] res_o
);

    localparam int MW = ELEM_WIDTH - 1 - EXP_WIDTH;

    logic                  a_nan;
    logic                  b_nan;
    logic                  a_gt;
    logic                  b_gt;
    logic                  pick_b;
    logic [ELEM_WIDTH-2:0] a_mag;
    logic [ELEM_WIDTH-2:0] b_mag;
    logic [ELEM_WIDTH-1:0] qnan;

    assign a_nan = is_nan(ELEM_MAX'(a_i), EXP_WIDTH, ELEM_WIDTH);
    assign b_nan = is_nan(ELEM_MAX'(b_i), EXP_WIDTH, ELEM_WIDTH);
    assign a_mag = a_i[ELEM_WIDTH-2:0];
    assign b_mag = b_i[ELEM_WIDTH-2:0];

    always_comb begin
        qnan = '0;
        qnan[ELEM_WIDTH-2 -: EXP_WIDTH] = '1;
        qnan[MW-1] = 1'b1;
    end

    // Sign-magnitude order; +0 beats -0 through the sign rule
    always_comb begin
        a_gt = 1'b0;
        b_gt = 1'b0;
        if (a_i[ELEM_WIDTH-1] != b_i[ELEM_WIDTH-1]) begin
            a_gt = ~a_i[ELEM_WIDTH-1];
            b_gt = a_i[ELEM_WIDTH-1];
        end else if (!a_i[ELEM_WIDTH-1]) begin
            a_gt = a_mag > b_mag;
            b_gt = b_mag > a_mag;
        end else begin
            a_gt = a_mag < b_mag;
            b_gt = b_mag < a_mag;
        end
    end

    assign pick_b = (op_i == MINMAX_MAX) ? b_gt : a_gt;

    always_comb begin
        res_o = a_i;
        unique case (1'b1)
            a_nan & b_nan:   res_o = qnan;
            a_nan & ~b_nan:  res_o = b_i;
            ~a_nan & b_nan:  res_o = a_i;
            default:         res_o = pick_b ? b_i : a_i;
        endcase
    end

`ifdef VPU_FP_MINMAX_FLAGS_EN
    assign snan_o = (a_nan & ~a_i[MW-1]) | (b_nan & ~b_i[MW-1]);
`endif

endmodule

// File: rtl/vpu_fp_minmax_lanes.sv
// Packed-lane FP maxNum/minNum with fixed-latency pipeline and credit queue.
// Define VPU_FP_MINMAX_FLAGS_EN to add the per-lane sNaN invalid_o output.
module vpu_fp_minmax_lanes
    import vpu_fp_minmax_lanes_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int ELEM_WIDTH   = 32,
    parameter int EXP_WIDTH    = 8,
    parameter int CMP_LATENCY  = 2,
    parameter int OQ_DEPTH_LG2 = 2
) (
    input logic                  clk,
    input logic                  rst,
    vpu_fp_minmax_lanes_if.slave bus
);

    localparam int RW    = NUM_LANES * ELEM_WIDTH;
`ifdef VPU_FP_MINMAX_FLAGS_EN
    localparam int DW    = RW + NUM_LANES;
`else
    localparam int DW    = RW;
`endif
    localparam int DEPTH = 1 << OQ_DEPTH_LG2;
    localparam int CW    = OQ_DEPTH_LG2 + 3;

    logic                   ready;
    logic                   accept;
    logic                   pop;
    logic [RW-1:0]          cmp_res;
    logic [DW-1:0]          cmp_data;
    logic [CMP_LATENCY-1:0] stage_valid_q;
    logic [CMP_LATENCY-1:0] stage_valid_d;
    logic [DW-1:0]          stage_data_q [CMP_LATENCY];
    logic [DW-1:0]          stage_data_d [CMP_LATENCY];
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          occ;
    logic [OQ_DEPTH_LG2:0]  oq_count;
    logic                   oq_valid;
    logic [DW-1:0]          oq_data;

`ifdef VPU_FP_MINMAX_FLAGS_EN
    logic [NUM_LANES-1:0]   cmp_inv;
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        vpu_fp_minmax_lane #(
            .ELEM_WIDTH(ELEM_WIDTH),
            .EXP_WIDTH (EXP_WIDTH)
        ) u_lane (
            .a_i   (bus.operand_0[g*ELEM_WIDTH +: ELEM_WIDTH]),
            .b_i   (bus.operand_1[g*ELEM_WIDTH +: ELEM_WIDTH]),
            .op_i  (bus.op_i),
`ifdef VPU_FP_MINMAX_FLAGS_EN
            .snan_o(cmp_inv[g]),
`endif
            .res_o (cmp_res[g*ELEM_WIDTH +: ELEM_WIDTH])
        );
    end

`ifdef VPU_FP_MINMAX_FLAGS_EN
    assign cmp_data = {cmp_inv, cmp_res};
`else
    assign cmp_data = cmp_res;
`endif

    // Credits cover every in-flight stage, so the queue cannot overflow
    always_comb begin
        inflight = '0;
        for (int i = 0; i < CMP_LATENCY; i++) begin
            inflight = inflight + CW'(stage_valid_q[i]);
        end
        occ = inflight + CW'(oq_count);
    end

    assign pop    = oq_valid & bus.result_ready_i;
    assign ready  = ~rst & ((occ - CW'(pop)) < CW'(DEPTH));
    assign accept = bus.start_i & ready;

    always_comb begin
        for (int i = CMP_LATENCY - 1; i > 0; i--) begin
            stage_valid_d[i] = stage_valid_q[i-1];
            stage_data_d[i]  = stage_data_q[i-1];
        end
        stage_valid_d[0] = accept;
        stage_data_d[0]  = cmp_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_q <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
        end
        stage_data_q <= stage_data_d;
    end

    sal_fifo #(
        .DEPTH_LG2 (OQ_DEPTH_LG2),
        .DATA_WIDTH(DW)
    ) u_oq (
        .clk        (clk),
        .rst        (rst),
        .push_i     (stage_valid_q[CMP_LATENCY-1]),
        .push_data_i(stage_data_q[CMP_LATENCY-1]),
        .pop_i      (pop),
        .pop_data_o (oq_data),
        .valid_o    (oq_valid),
        .count_o    (oq_count)
    );

    assign bus.ready_o  = ready;
    assign bus.done_o   = oq_valid;
    assign bus.result_o = oq_data[RW-1:0];
`ifdef VPU_FP_MINMAX_FLAGS_EN
    assign bus.invalid_o = oq_data[DW-1:RW];
`endif

endmodule

// File: tb/tb_vpu_fp_minmax_lanes.sv
// Scoreboard bench for vpu_fp_minmax_lanes: directed cases plus random stream.
// Flag checks are compiled in with VPU_FP_MINMAX_FLAGS_EN.
module tb_vpu_fp_minmax_lanes;
    import vpu_fp_minmax_lanes_pkg::*;

    localparam int NL = 4;
    localparam int EW = 32;
    localparam int W  = NL * EW;

    typedef struct packed {
        logic [W-1:0]  res;
        logic [NL-1:0] inv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vpu_fp_minmax_lanes_if #(.NUM_LANES(NL), .ELEM_WIDTH(EW)) bus ();

    vpu_fp_minmax_lanes #(
        .NUM_LANES   (NL),
        .ELEM_WIDTH  (EW),
        .EXP_WIDTH   (8),
        .CMP_LATENCY (2),
        .OQ_DEPTH_LG2(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_push = 0;
    int   n_pop  = 0;
    bit   stream_done = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    // Reference: order elements by a signed integer key (sign-magnitude value)
    function automatic logic [31:0] ref_lane(input logic [31:0] a, input logic [31:0] b, input minmax_op_t op);
        bit an;
        bit bn;
        int ka;
        int kb;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        if (an && bn) return FP32_QNAN;
        if (an) return b;
        if (bn) return a;
        ka = int'({1'b0, a[30:0]});
        kb = int'({1'b0, b[30:0]});
        if (a[31]) ka = -ka;
        if (b[31]) kb = -kb;
        if (ka == 0 && kb == 0 && a[31] != b[31]) begin
            if (op == MINMAX_MAX) return a[31] ? b : a;
            return a[31] ? a : b;
        end
        if (ka == kb) return a;
        if (op == MINMAX_MAX) return (kb > ka) ? b : a;
        return (kb < ka) ? b : a;
    endfunction

    function automatic bit ref_snan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0) && !x[22];
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input minmax_op_t op);
        exp_t e;
        for (int l = 0; l < NL; l++) begin
            e.res[l*EW +: EW] = ref_lane(a[l*EW +: EW], b[l*EW +: EW], op);
            e.inv[l] = ref_snan(a[l*EW +: EW]) || ref_snan(b[l*EW +: EW]);
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_elem();
        case ($urandom_range(0, 15))
            0:  return 32'h0000_0000;
            1:  return 32'h8000_0000;
            2:  return 32'h7F80_0000;
            3:  return 32'hFF80_0000;
            4:  return 32'h7FC0_0000;
            5:  return 32'h7F80_0001;
            6:  return 32'hFFC0_0123;
            7:  return 32'h3F80_0000;
            8:  return 32'hBF80_0000;
            9:  return 32'h0000_0001;
            10: return 32'h8000_0001;
            11: return 32'h7F7F_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic rnd_vec(output logic [W-1:0] a, output logic [W-1:0] b);
        logic [31:0] x;
        for (int l = 0; l < NL; l++) begin
            x = rnd_elem();
            a[l*EW +: EW] = x;
            case ($urandom_range(0, 7))
                0, 1:    b[l*EW +: EW] = x;
                2:       b[l*EW +: EW] = x ^ 32'h8000_0000;
                default: b[l*EW +: EW] = rnd_elem();
            endcase
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input minmax_op_t op);
        bit ok;
        ok = 0;
        bus.operand_0 = a;
        bus.operand_1 = b;
        bus.op_i      = op;
        bus.start_i   = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.ready_o) begin
                ok = 1;
                exp_q.push_back(model(a, b, op));
                n_push++;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no accept required accept");
        end
    endtask

    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.done_o && k < 20);
    endtask

    // Monitor: every popped result is compared against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done_o && bus.result_ready_i) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %h required none", bus.result_o);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", bus.result_o, e.res);
`ifdef VPU_FP_MINMAX_FLAGS_EN
                check("sb_invalid", W'(bus.invalid_o), W'(e.inv));
`endif
            end
        end
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int lat;
        int acc;
        int seen;

        bus.operand_0      = '0;
        bus.operand_1      = '0;
        bus.op_i           = MINMAX_MAX;
        bus.start_i        = 1'b0;
        bus.result_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", W'(bus.ready_o), W'(0));
        check("reset_done", W'(bus.done_o), W'(0));
        check("reset_result", bus.result_o, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", W'(bus.ready_o), W'(1));
        @(posedge clk);
        #1;

        a = 128'h00000000_40600000_C0000000_3F800000;
        b = 128'h80000000_40600000_BF800000_40000000;
        send(a, b, MINMAX_MAX);
        wait_done(lat);
        check("max_latency", W'(lat), W'(3));
        check("max_result", bus.result_o, 128'h00000000_40600000_BF800000_40000000);
        @(posedge clk);
        #1;

        send(a, b, MINMAX_MIN);
        wait_done(lat);
        check("min_latency", W'(lat), W'(3));
        check("min_result", bus.result_o, 128'h80000000_40600000_C0000000_3F800000);
        @(posedge clk);
        #1;

        a = 128'h00000000_00000000_7F800001_7FC00001;
        b = 128'h00000000_00000000_7F800001_3F800000;
        send(a, b, MINMAX_MAX);
        wait_done(lat);
        check("nan_result", bus.result_o, 128'h00000000_00000000_7FC00000_3F800000);
`ifdef VPU_FP_MINMAX_FLAGS_EN
        check("nan_invalid", W'(bus.invalid_o), W'(4'b0010));
`endif
        @(posedge clk);
        #1;

        bus.result_ready_i = 1'b0;
        rnd_vec(a, b);
        bus.operand_0 = a;
        bus.operand_1 = b;
        bus.op_i      = MINMAX_MAX;
        bus.start_i   = 1'b1;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.ready_o) begin
                acc++;
                exp_q.push_back(model(a, b, bus.op_i));
                n_push++;
                @(posedge clk);
                #1;
                rnd_vec(a, b);
                bus.operand_0 = a;
                bus.operand_1 = b;
                bus.op_i      = minmax_op_t'($urandom_range(0, 1));
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("bp_accepted", W'(acc), W'(4));
        @(negedge clk);
        check("bp_ready_low", W'(bus.ready_o), W'(0));
        @(posedge clk);
        #1;
        bus.start_i        = 1'b0;
        bus.result_ready_i = 1'b1;
        @(negedge clk);
        check("bp_ready_reassert", W'(bus.ready_o), W'(1));
        check("bp_pop0", W'(bus.done_o), W'(1));
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("bp_pop_consec", W'(bus.done_o), W'(1));
        end
        @(negedge clk);
        check("bp_drained", W'(bus.done_o), W'(0));
        @(posedge clk);
        #1;

        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    rnd_vec(a, b);
                    send(a, b, minmax_op_t'($urandom_range(0, 1)));
                end
                stream_done = 1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    bus.result_ready_i = ($urandom_range(0, 2) != 0);
                end
            end
        join
        @(posedge clk);
        #1;
        bus.result_ready_i = 1'b1;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        check("stream_drained", W'(exp_q.size()), W'(0));
        check("push_pop_balance", W'(n_pop), W'(n_push));
        @(posedge clk);
        #1;

        rnd_vec(a, b);
        send(a, b, MINMAX_MAX);
        rnd_vec(a, b);
        send(a, b, MINMAX_MIN);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_ready_low", W'(bus.ready_o), W'(0));
        check("rst_done_low", W'(bus.done_o), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_after", W'(bus.ready_o), W'(1));
        check("rst_done_after", W'(bus.done_o), W'(0));
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done_o) seen = 1;
        end
        check("rst_no_emit", W'(seen), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
